// File: rtl/gol_grid_if.sv
// Host-side bundle for the Game-of-Life grid engine:
// row load, run control, rule masks, readback and status.
interface gol_grid_if #(
  parameter int W  = 8,
  parameter int RW = 3,
  parameter int GW = 8
);
  logic          load_en;
  logic [RW-1:0] load_row;
  logic [W-1:0]  load_data;
  logic          start;
  logic [GW-1:0] gens;
  logic          wrap;
  logic [8:0]    birth_mask;
  logic [8:0]    surv_mask;
  logic [RW-1:0] rd_row;
  logic [W-1:0]  rd_data;
  logic          busy;
  logic          done;
  logic          stable;
  logic [GW-1:0] gen_count;

  modport master (
    output load_en, load_row, load_data,
    output start, gens, wrap,
    output birth_mask, surv_mask, rd_row,
    input  rd_data, busy, done,
    input  stable, gen_count
  );

  modport slave (
    input  load_en, load_row, load_data,
    input  start, gens, wrap,
    input  birth_mask, surv_mask, rd_row,
    output rd_data, busy, done,
    output stable, gen_count
  );
endinterface

// File: rtl/gol_grid.sv
// Register-resident W x H Game-of-Life engine.
// Evaluates one row per clock, commits a full generation at once.
module gol_grid #(
  parameter int W  = 8,
  parameter int H  = 8,
  parameter int RW = 3,
  parameter int GW = 8
) (
  input  logic      clk,
  input  logic      rst,
  gol_grid_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_FIN    = 2'd3;

  localparam logic [RW:0]   HL    = (RW+1)'(H);
  localparam logic [RW-1:0] RLAST = RW'(H-1);

  logic [1:0]    r_state;
  logic [W-1:0]  r_cur [H];
  logic [W-1:0]  r_nxt [H];
  logic [RW-1:0] r_row;
  logic          r_chg;
  logic [GW-1:0] r_gens;
  logic [GW-1:0] r_gen;
  logic          r_wrap;
  logic [8:0]    r_bm;
  logic [8:0]    r_sm;
  logic [W-1:0]  r_rd;
  logic          r_busy;
  logic          r_done;
  logic          r_stable;

  logic [W-1:0]  w_up;
  logic [W-1:0]  w_mid;
  logic [W-1:0]  w_dn;
  logic [W+1:0]  w_xu;
  logic [W+1:0]  w_xm;
  logic [W+1:0]  w_xd;
  logic [3:0]    w_n [W];
  logic [W-1:0]  w_row;
  logic          w_ld_ok;
  logic          w_rd_ok;

  assign w_ld_ok = {1'b0, bus.load_row} < HL;
  assign w_rd_ok = {1'b0, bus.rd_row} < HL;

  // Vertical neighbours; off-grid rows read as dead unless wrapping.
  always_comb begin
    w_mid = r_cur[r_row];
    w_up  = '0;
    w_dn  = '0;
    if (r_row != '0)
      w_up = r_cur[r_row - RW'(1)];
    else if (r_wrap)
      w_up = r_cur[RLAST];
    if (r_row != RLAST)
      w_dn = r_cur[r_row + RW'(1)];
    else if (r_wrap)
      w_dn = r_cur[0];
  end

  // Pad each row with its column -1 and column W neighbours.
  function automatic logic [W+1:0] ext(
    input logic [W-1:0] v,
    input logic         wr
  );
    return {wr & v[0], v, wr & v[W-1]};
  endfunction

  assign w_xu = ext(w_up, r_wrap);
  assign w_xm = ext(w_mid, r_wrap);
  assign w_xd = ext(w_dn, r_wrap);

  always_comb begin
    w_n   = '{default: '0};
    w_row = '0;
    for (int c = 0; c < W; c++) begin
      w_n[c] = 4'(w_xu[c]) + 4'(w_xu[c+1])
             + 4'(w_xu[c+2]) + 4'(w_xm[c])
             + 4'(w_xm[c+2]) + 4'(w_xd[c])
             + 4'(w_xd[c+1]) + 4'(w_xd[c+2]);
      w_row[c] = w_mid[c] ? r_sm[w_n[c]]
                          : r_bm[w_n[c]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cur    <= '{default: '0};
      r_nxt    <= '{default: '0};
      r_row    <= '0;
      r_chg    <= 1'b0;
      r_gens   <= '0;
      r_gen    <= '0;
      r_wrap   <= 1'b0;
      r_bm     <= '0;
      r_sm     <= '0;
      r_rd     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_stable <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_rd   <= w_rd_ok ? r_cur[bus.rd_row] : '0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_gens   <= bus.gens;
            r_wrap   <= bus.wrap;
            r_bm     <= bus.birth_mask;
            r_sm     <= bus.surv_mask;
            r_gen    <= '0;
            r_stable <= 1'b0;
            r_busy   <= 1'b1;
            r_row    <= '0;
            r_chg    <= 1'b0;
            r_state  <= (bus.gens == '0) ? S_FIN
                                         : S_RUN;
          end else if (bus.load_en && w_ld_ok) begin
            r_cur[bus.load_row] <= bus.load_data;
          end
        end
        S_RUN: begin
          r_nxt[r_row] <= w_row;
          if (w_row != w_mid)
            r_chg <= 1'b1;
          if (r_row == RLAST)
            r_state <= S_COMMIT;
          else
            r_row <= r_row + RW'(1);
        end
        S_COMMIT: begin
          r_cur <= r_nxt;
          r_gen <= r_gen + GW'(1);
          if (!r_chg) begin
            r_stable <= 1'b1;
            r_state  <= S_FIN;
          end else if (r_gen + GW'(1) == r_gens) begin
            r_state <= S_FIN;
          end else begin
            r_row   <= '0;
            r_chg   <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_data   = r_rd;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.stable    = r_stable;
  assign bus.gen_count = r_gen;
endmodule

// File: tb/tb_gol_grid.sv
// Directed bench for gol_grid with a neighbour-counting
// reference model and a per-cycle status/readback checker.
module tb_gol_grid;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int RW = 3;
  localparam int GW = 8;
  localparam int TO = 3000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gol_grid_if #(.W(W), .RW(RW), .GW(GW)) bif();

  gol_grid #(.W(W), .H(H), .RW(RW), .GW(GW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  bit [W-1:0] mg [H];
  bit [W-1:0] keep [H];
  logic [RW-1:0] rd_q;

  bit win_en = 0;
  bit rb_en = 0;
  int t_s;
  int e_len;
  int e_gc;
  bit e_st;
  int rel;
  int gc;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_q <= bif.rd_row;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h @cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Status and readback checker, sampled mid-cycle.
  always @(negedge clk) begin
    if (win_en) begin
      rel = cyc - t_s;
      if (rel >= 1) begin
        chk("busy", bif.busy, rel < e_len);
        chk("done", bif.done, rel == e_len);
        gc = (rel - 1) / (H + 1);
        if (gc > e_gc) gc = e_gc;
        chk("gen_count", bif.gen_count, gc);
        chk("stable", bif.stable,
            (rel >= e_len - 1) ? e_st : 1'b0);
      end
    end
    if (rb_en)
      chk("rd_data", bif.rd_data, mg[rd_q]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_model(input bit wr,
                            input bit [8:0] b,
                            input bit [8:0] s);
    bit [W-1:0] t [H];
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            rr = r + dr;
            cc = c + dc;
            if (wr) begin
              rr = (rr + H) % H;
              cc = (cc + W) % W;
            end
            if (!(dr == 0 && dc == 0) &&
                rr >= 0 && rr < H &&
                cc >= 0 && cc < W)
              n += int'(mg[rr][cc]);
          end
        end
        t[r][c] = mg[r][c] ? s[n] : b[n];
      end
    end
    mg = t;
  endtask

  task automatic clear_model();
    for (int r = 0; r < H; r++) mg[r] = '0;
  endtask

  task automatic load_all();
    for (int r = 0; r < H; r++) begin
      bif.load_en   = 1'b1;
      bif.load_row  = RW'(r);
      bif.load_data = mg[r];
      tick();
    end
    bif.load_en = 1'b0;
  endtask

  task automatic readback();
    tick();
    rb_en = 1;
    for (int r = 0; r < H; r++) begin
      bif.rd_row = RW'(r);
      tick();
    end
    tick();
    rb_en = 0;
  endtask

  task automatic run(input int g, input bit wr,
                     input bit [8:0] b, input bit [8:0] s,
                     input bit noise, output int lat);
    bit [W-1:0] prev [H];
    bit same;
    int k;
    k = 0;
    same = 0;
    for (int i = 0; i < g && !same; i++) begin
      prev = mg;
      step_model(wr, b, s);
      k++;
      same = 1;
      for (int r = 0; r < H; r++)
        if (mg[r] != prev[r]) same = 0;
    end
    e_gc  = k;
    e_st  = same;
    e_len = 2 + k * (H + 1);
    bif.start      = 1'b1;
    bif.gens       = GW'(g);
    bif.wrap       = wr;
    bif.birth_mask = b;
    bif.surv_mask  = s;
    bif.load_en    = 1'b1;
    bif.load_row   = '0;
    bif.load_data  = '1;
    t_s    = cyc;
    win_en = 1;
    tick();
    bif.start   = 1'b0;
    bif.load_en = 1'b0;
    lat = -1;
    for (int i = 0; i < TO; i++) begin
      if (noise) begin
        bif.load_en    = 1'b1;
        bif.load_row   = RW'($urandom);
        bif.load_data  = W'($urandom);
        bif.start      = 1'b1;
        bif.gens       = GW'($urandom);
        bif.wrap       = ~wr;
        bif.birth_mask = 9'($urandom);
        bif.surv_mask  = 9'($urandom);
      end
      tick();
      if (bif.done) begin
        lat = cyc - t_s;
        break;
      end
    end
    bif.load_en = 1'b0;
    bif.start   = 1'b0;
    if (lat < 0)
      chk("done_timeout", 0, 1);
    tick();
    tick();
    win_en = 0;
  endtask

  int lat;
  bit seen;

  initial begin
    bif.load_en    = 1'b0;
    bif.load_row   = '0;
    bif.load_data  = '0;
    bif.start      = 1'b0;
    bif.gens       = '0;
    bif.wrap       = 1'b0;
    bif.birth_mask = '0;
    bif.surv_mask  = '0;
    bif.rd_row     = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", bif.busy, 0);
    chk("rst_done", bif.done, 0);
    chk("rst_stable", bif.stable, 0);
    chk("rst_gc", bif.gen_count, 0);
    chk("rst_rd", bif.rd_data, 0);
    clear_model();
    readback();

    // Blinker, dead border, one generation.
    clear_model();
    mg[3] = 8'h1C;
    load_all();
    readback();
    run(1, 0, 9'h008, 9'h00C, 0, lat);
    chk("blink_lat", lat, 11);
    chk("blink_m2", mg[2], 8'h08);
    chk("blink_m3", mg[3], 8'h08);
    chk("blink_m4", mg[4], 8'h08);
    chk("blink_m5", mg[5], 8'h00);
    readback();

    // Edge row, dead border then torus.
    clear_model();
    mg[0] = 8'h38;
    load_all();
    run(1, 0, 9'h008, 9'h00C, 0, lat);
    chk("edge0_m0", mg[0], 8'h10);
    chk("edge0_m1", mg[1], 8'h10);
    chk("edge0_m7", mg[7], 8'h00);
    readback();
    clear_model();
    mg[0] = 8'h38;
    load_all();
    run(1, 1, 9'h008, 9'h00C, 0, lat);
    chk("edge1_m7", mg[7], 8'h10);
    chk("edge1_m0", mg[0], 8'h10);
    chk("edge1_m1", mg[1], 8'h10);
    readback();

    // Glider on torus returns home after 32 gens.
    clear_model();
    mg[0] = 8'h02;
    mg[1] = 8'h04;
    mg[2] = 8'h07;
    keep = mg;
    load_all();
    run(32, 1, 9'h008, 9'h00C, 1, lat);
    chk("glider_lat", lat, 290);
    for (int r = 0; r < H; r++)
      chk("glider_home", mg[r], keep[r]);
    readback();

    // Still life stops early.
    clear_model();
    mg[3] = 8'h18;
    mg[4] = 8'h18;
    load_all();
    run(10, 0, 9'h008, 9'h00C, 0, lat);
    chk("block_lat", lat, 11);
    chk("block_st", e_st, 1);
    chk("block_gc", bif.gen_count, 1);
    chk("block_stable", bif.stable, 1);
    readback();

    // Zero generations, loads while busy ignored.
    clear_model();
    mg[3] = 8'h1C;
    load_all();
    run(0, 0, 9'h008, 9'h00C, 1, lat);
    chk("zero_lat", lat, 2);
    chk("zero_gc", bif.gen_count, 0);
    readback();

    // Reset during the third generation.
    bif.start      = 1'b1;
    bif.gens       = GW'(5);
    bif.wrap       = 1'b0;
    bif.birth_mask = 9'h008;
    bif.surv_mask  = 9'h00C;
    t_s = cyc;
    tick();
    bif.start = 1'b0;
    while (cyc < t_s + 22) tick();
    chk("mid_gc", bif.gen_count, 2);
    chk("mid_busy", bif.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ab_busy", bif.busy, 0);
    chk("ab_gc", bif.gen_count, 0);
    chk("ab_stable", bif.stable, 0);
    chk("ab_rd", bif.rd_data, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bif.done) seen = 1;
      tick();
    end
    chk("ab_nodone", seen, 0);
    clear_model();
    readback();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: no finish, %0d failed so far",
             fails);
    $fatal(1, "watchdog");
  end
endmodule
